// File: rtl/risc_pkg.sv
// Shared types and constants for the RISC-V front end.
// Contents: IFU FSM state type, buffered fetch entry payload, NOP encoding,
// base opcode constants and a word-alignment helper.
package risc_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b000_0011;
  localparam logic [6:0] OP_STORE  = 7'b010_0011;
  localparam logic [6:0] OP_R      = 7'b011_0011;
  localparam logic [6:0] OP_I      = 7'b001_0011;
  localparam logic [6:0] OP_BRANCH = 7'b110_0011;
  localparam logic [6:0] OP_JAL    = 7'b110_1111;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } ifu_state_t;

  // One buffered fetch: address of the word and the word itself
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Force a byte address onto a 32-bit word boundary
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Instruction buffer: synchronous FIFO of {pc, instr} entries.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_push / i_data     write an entry (ignored when full)
//   i_pop               remove the head entry (ignored when empty)
//   i_clear             drop every entry; wins over push and pop
//   o_head              current head entry (undefined when empty)
//   o_count             number of stored entries
//   o_empty / o_full    occupancy flags
module ifu_fifo
  import risc_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_push,
  input  fetch_entry_t                   i_data,
  input  logic                           i_pop,
  input  logic                           i_clear,
  output fetch_entry_t                   o_head,
  output logic [$clog2(DEPTH+1)-1:0]     o_count,
  output logic                           o_empty,
  output logic                           o_full
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while counted valid
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, issues word fetches to instruction
// memory, buffers returned words and presents them decoded into fields.
// Redirects flush the buffer and discard responses of wrong-path fetches.
// Optional feature macro: IFU_PERF_CNT_EN builds the fetch/flush counters;
// without it perf_fetch_cnt and perf_flush_cnt are tied to zero.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   imem_req_valid/ready/addr         fetch request handshake
//   imem_rsp_valid/data               in-order fetch responses, no backpressure
//   redirect_valid/redirect_pc        taken branch/jump target
//   instr_valid/ready, instr, instr_pc buffered instruction to decode
//   opcode..funct7                    instruction fields of instr
//   perf_fetch_cnt, perf_flush_cnt    delivered instructions / redirects
module instr_fetch_unit
  import risc_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH      = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  ifu_state_t    r_state;
  ifu_state_t    w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [31:0]   w_redirect_pc;
  logic [OW-1:0] r_outstanding;
  logic [OW-1:0] r_drop_cnt;
  logic [OW-1:0] w_drop_nxt;
  logic [OW-1:0] w_out_after_rsp;
  logic          w_rsp_accept;
  logic          w_rsp_drop;
  logic          w_push;
  logic          w_pop;
  logic          w_req_fire;
  logic          w_credit_ok;
  logic [CW-1:0] w_fifo_count;
  logic          w_fifo_empty;
  logic          w_fifo_full;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_data;

  assign w_redirect_pc = word_align(redirect_pc);

  // Responses with nothing in flight are stale (e.g. issued before a reset)
  assign w_rsp_accept    = imem_rsp_valid && (r_outstanding != '0);
  assign w_rsp_drop      = w_rsp_accept && (r_drop_cnt != '0);
  assign w_push          = w_rsp_accept && (r_drop_cnt == '0) && !redirect_valid;
  assign w_out_after_rsp = r_outstanding - OW'(w_rsp_accept);

  // Buffer credit counts in-flight fetches, including ones that will be dropped
  assign w_credit_ok = ((32'(w_fifo_count) + 32'(r_outstanding)) < FIFO_DEPTH) &&
                       (32'(r_outstanding) < MAX_OUTSTANDING);

  assign imem_req_valid = (r_state != S_BOOT) && w_credit_ok && !redirect_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // Kept responses are sequential from the last redirect target, so one PC tracks them
  assign w_push_data.pc    = r_rsp_pc;
  assign w_push_data.instr = imem_rsp_data;

  assign instr_valid = !w_fifo_empty;
  assign instr       = instr_valid ? w_head.instr : NOP_INSTR;
  assign instr_pc    = instr_valid ? w_head.pc : 32'h0000_0000;
  assign opcode      = instr[6:0];
  assign rd          = instr[11:7];
  assign funct3      = instr[14:12];
  assign rs1         = instr[19:15];
  assign rs2         = instr[24:20];
  assign funct7      = instr[31:25];
  assign w_pop       = instr_valid && instr_ready;

  // Drop counter: reload from in-flight fetches on redirect, else count discards down
  always_comb begin
    w_drop_nxt = r_drop_cnt;
    if (redirect_valid) begin
      w_drop_nxt = w_out_after_rsp;
    end else if (w_rsp_drop) begin
      w_drop_nxt = r_drop_cnt - OW'(1);
    end
  end

  // Next state: boot lasts one cycle, drain while wrong-path responses remain
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:          w_state_nxt = S_RUN;
      S_RUN, S_DRAIN:  w_state_nxt = (w_drop_nxt != '0) ? S_DRAIN : S_RUN;
      default:         w_state_nxt = S_BOOT;
    endcase
  end

  // State, PCs and in-flight accounting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_BOOT;
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_drop_cnt    <= w_drop_nxt;
      r_outstanding <= w_out_after_rsp + OW'(w_req_fire);
      if (redirect_valid) begin
        r_fetch_pc <= w_redirect_pc;
        r_rsp_pc   <= w_redirect_pc;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_push)     r_rsp_pc   <= r_rsp_pc + 32'd4;
      end
    end
  end

  ifu_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_clear (redirect_valid),
    .o_head  (w_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

`ifdef IFU_PERF_CNT_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_flush;

  // Free-running wrap-around event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetch <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_pop)          r_perf_fetch <= r_perf_fetch + 32'd1;
      if (redirect_valid) r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_flush_cnt = r_perf_flush;
`else
  assign perf_fetch_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

  // A kept response must always find room in the buffer
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(w_push && w_fifo_full));

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int          DEPTH = 2;
  localparam int          MAXO  = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7         (funct7),
    .rd             (rd),
    .rs1            (rs1),
    .rs2            (rs2),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pending memory read: address, earliest response cycle, fetch-stream epoch
  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    int unsigned epoch;
  } mreq_t;

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] exp_addr;
  } redir_vec_t;

  mreq_t       mq[$];
  int unsigned total, bad, cyc, epoch;
  int unsigned lat_min, lat_max;
  int          buffered;
  int unsigned n_deliv, n_flush;
  logic [31:0] exp_pc, exp_fetch;
  logic        prev_req_pending;
  logic [31:0] prev_req_addr;
  logic        await_req, await_pc;
  logic [31:0] first_req_addr, first_pc;
  int          first_req_cyc, first_valid_cyc;
  logic        coincide_mode, coincide_hit;
  logic        stray_rsp;
  int unsigned hold_checks;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_req_addr"}, imem_req_addr, 32'h0);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_instr"}, instr, NOP);
    chk({tag, "_instr_pc"}, instr_pc, 32'h0);
    chk({tag, "_perf_fetch"}, perf_fetch_cnt, 32'h0);
    chk({tag, "_perf_flush"}, perf_flush_cnt, 32'h0);
  endtask

  // Ends at a falling edge with rst_n released; the following cycle is the boot cycle
  task automatic do_reset();
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
    mq.delete();
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("rst");
    @(negedge clk);
    rst_n            = 1'b1;
    cyc              = 0;
    epoch++;
    buffered         = 0;
    exp_pc           = 32'h0;
    exp_fetch        = 32'h0;
    n_deliv          = 0;
    n_flush          = 0;
    prev_req_pending = 1'b0;
    await_req        = 1'b0;
    await_pc         = 1'b0;
    first_req_cyc    = -1;
    first_valid_cyc  = -1;
  endtask

  // One clock cycle: drive inputs, check against the stream model, advance the model
  task automatic step(input logic rdy, input logic irdy, input logic redir, input logic [31:0] rpc);
    logic        rsp;
    mreq_t       r;
    mreq_t       m;
    logic [31:0] w;
    int          outst;
    logic        exp_req_valid;
    rsp = 1'b0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      r   = mq.pop_front();
      rsp = 1'b1;
    end
    if (coincide_mode && rsp && buffered > 0) begin
      redir         = 1'b1;
      irdy          = 1'b1;
      coincide_hit  = 1'b1;
      coincide_mode = 1'b0;
    end
    imem_req_ready = rdy;
    instr_ready    = irdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(r.addr) : $urandom();
    if (!rsp && stray_rsp) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      stray_rsp      = 1'b0;
    end
    #1;
    outst = mq.size() + (rsp ? 1 : 0);

    chk("buffer_bound", 32'(buffered <= DEPTH), 32'd1);
    chk("inflight_bound", 32'(outst <= MAXO), 32'd1);
    chk("instr_valid", 32'(instr_valid), 32'(buffered > 0));
    exp_req_valid = (cyc != 0) && (buffered + outst < DEPTH) && (outst < MAXO) && !redir;
    chk("req_valid", 32'(imem_req_valid), 32'(exp_req_valid));
    if (prev_req_pending && !redir) begin
      hold_checks++;
      chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
      chk("req_hold_addr", imem_req_addr, prev_req_addr);
    end
    if (imem_req_valid) chk("req_addr", imem_req_addr, exp_fetch);

    if (instr_valid) begin
      w = mem_word(exp_pc);
      chk("instr_pc", instr_pc, exp_pc);
      chk("instr", instr, w);
      chk("opcode", 32'(opcode), 32'(w[6:0]));
      chk("rd", 32'(rd), 32'(w[11:7]));
      chk("funct3", 32'(funct3), 32'(w[14:12]));
      chk("rs1", 32'(rs1), 32'(w[19:15]));
      chk("rs2", 32'(rs2), 32'(w[24:20]));
      chk("funct7", 32'(funct7), 32'(w[31:25]));
      if (first_valid_cyc < 0) first_valid_cyc = int'(cyc);
    end else begin
      chk("idle_instr", instr, NOP);
      chk("idle_pc", instr_pc, 32'h0);
      chk("idle_opcode", 32'(opcode), 32'h13);
    end

    if (instr_valid && irdy) begin
      if (await_pc) begin
        first_pc = instr_pc;
        await_pc = 1'b0;
      end
      exp_pc = exp_pc + 32'd4;
      buffered--;
      n_deliv++;
    end
    if (rsp && !redir && r.epoch == epoch) buffered++;
    if (imem_req_valid && rdy) begin
      if (first_req_cyc < 0) first_req_cyc = int'(cyc);
      if (await_req) begin
        first_req_addr = imem_req_addr;
        await_req      = 1'b0;
      end
      m.addr  = imem_req_addr;
      m.due   = cyc + $urandom_range(lat_max, lat_min);
      m.epoch = epoch;
      mq.push_back(m);
      exp_fetch = exp_fetch + 32'd4;
    end
    prev_req_pending = imem_req_valid && !rdy;
    prev_req_addr    = imem_req_addr;
    if (redir) begin
      epoch++;
      buffered  = 0;
      exp_pc    = rpc & 32'hFFFF_FFFC;
      exp_fetch = rpc & 32'hFFFF_FFFC;
      n_flush++;
      await_req = 1'b1;
      await_pc  = 1'b1;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    redir_vec_t  tbl[4];
    int unsigned h0;
    logic [31:0] exp_perf;

    total = 0; bad = 0; cyc = 0; epoch = 0; n_deliv = 0; n_flush = 0;
    buffered = 0; coincide_mode = 1'b0; coincide_hit = 1'b0; stray_rsp = 1'b0;
    hold_checks = 0; first_req_addr = 32'h0; first_pc = 32'h0;
    lat_min = 1; lat_max = 1;

    tbl[0] = '{rpc: 32'h0000_0203, exp_addr: 32'h0000_0200};
    tbl[1] = '{rpc: 32'h0000_0100, exp_addr: 32'h0000_0100};
    tbl[2] = '{rpc: 32'hFFFF_FFFE, exp_addr: 32'hFFFF_FFFC};
    tbl[3] = '{rpc: 32'h0000_1001, exp_addr: 32'h0000_1000};

    // Reset release, 1-cycle memory: first request cycle 1, first instruction cycle 3
    do_reset();
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("first_req_cycle", 32'(first_req_cyc), 32'd1);
    chk("first_valid_cycle", 32'(first_valid_cyc), 32'd3);

    // Decode stalled for 10 cycles: buffer fills, requests stop
    repeat (10) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_buffered", 32'(buffered), 32'(DEPTH));
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Memory not ready for 5 cycles: request address must hold
    h0 = hold_checks;
    repeat (5) step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("hold_seen", 32'((hold_checks - h0) >= 2), 32'd1);
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect to 0x100 with two fetches in flight
    do_reset();
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 10; i++) begin
      if (mq.size() == 2 && buffered == 0 && cyc > 0) break;
      step(1'b1, 1'b1, 1'b0, 32'h0);
    end
    chk("two_outstanding", 32'(mq.size()), 32'd2);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0100);
    repeat (15) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("redir100_first_pc", first_pc, 32'h0000_0100);
    chk("redir100_pending", 32'(await_pc), 32'd0);
`ifdef IFU_PERF_CNT_EN
    exp_perf = 32'd1;
`else
    exp_perf = 32'd0;
`endif
    chk("perf_flush_one", perf_flush_cnt, exp_perf);

    // Table of redirect targets and their word-aligned fetch addresses
    lat_min = 1; lat_max = 2;
    for (int i = 0; i < 4; i++) begin
      repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b1, tbl[i].rpc);
      repeat (12) step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("tbl_req_seen", 32'(await_req), 32'd0);
      chk("tbl_first_req_addr", first_req_addr, tbl[i].exp_addr);
      chk("tbl_first_pc", first_pc, tbl[i].exp_addr);
    end

    // Redirect in the same cycle as a decode handshake and a memory response
    lat_min = 1; lat_max = 1;
    coincide_hit  = 1'b0;
    coincide_mode = 1'b1;
    for (int i = 0; i < 40 && !coincide_hit; i++)
      step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 32'h0000_0400);
    coincide_mode = 1'b0;
    chk("coincide_hit", 32'(coincide_hit), 32'd1);
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("coincide_first_pc", first_pc, 32'h0000_0400);

    // Randomized traffic
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 19) == 0), $urandom());
    end
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);
`ifdef IFU_PERF_CNT_EN
    chk("perf_fetch_total", perf_fetch_cnt, 32'(n_deliv));
    chk("perf_flush_total", perf_flush_cnt, 32'(n_flush));
`else
    chk("perf_fetch_total", perf_fetch_cnt, 32'h0);
    chk("perf_flush_total", perf_flush_cnt, 32'h0);
`endif

    // Asynchronous reset pulse in mid-stream, then a stale response during boot
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    do_reset();
    stray_rsp = 1'b1;
    lat_min = 1; lat_max = 1;
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("post_rst_first_req", 32'(first_req_cyc), 32'd1);
    chk("post_rst_first_valid", 32'(first_valid_cyc), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
